// File: rtl/mult_share_pkg.sv
// Shared definitions for the multiplier-sharing controller: operand and
// product widths, FSM state encoding and the high-pass alignment helper.
package mult_share_pkg;

   localparam int PROD_W = 8;
   localparam int OPA_W  = 4;
   localparam int OPB_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } state_t;

   // The high pass multiplies by a[3] only, so P never exceeds 15.
   // Its low nibble is therefore the whole partial product, weighted by 8.
   function automatic logic [PROD_W-1:0] hiTerm(input logic [6:0] p);
      return {1'b0, p[3:0], 3'b000};
   endfunction

endpackage

// File: rtl/multiplier_sam.sv
// Combinational 3x4 unsigned multiplier shared by both requesters.
module multiplier_sam (
   input  logic [2:0] A_in,
   input  logic [3:0] B_in,
   output logic [6:0] P
);

   // Plain unsigned product, widened to 7 bits before multiplying.
   assign P = 7'(A_in) * 7'(B_in);

endmodule

// File: rtl/rr_arb2.sv
// Two-input arbiter that remembers which requester was granted last.
// Grants are only issued while the controller is able to accept.
module rr_arb2 #(
   parameter bit RR_EN = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_enable,
   input  logic i_valid0,
   input  logic i_valid1,
   output logic o_grant0,
   output logic o_grant1
);

   logic r_lastGrant;

   // Choose a winner; on a tie either alternate or favour requester 0.
   always_comb begin
      o_grant0 = 1'b0;
      o_grant1 = 1'b0;
      if (i_enable) begin
         if (i_valid0 && i_valid1) begin
            if (RR_EN && !r_lastGrant) begin
               o_grant1 = 1'b1;
            end else begin
               o_grant0 = 1'b1;
            end
         end else begin
            o_grant0 = i_valid0;
            o_grant1 = i_valid1;
         end
      end
   end

   // Record the winner; starts at 1 so requester 0 wins the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lastGrant <= 1'b1;
      end else if (o_grant0) begin
         r_lastGrant <= 1'b0;
      end else if (o_grant1) begin
         r_lastGrant <= 1'b1;
      end
   end

endmodule

// File: rtl/mult_share_ctrl.sv
// Sequences 4x4 multiplies from two requesters through one 3x4 multiplier:
// a low pass on a[2:0] followed by a high pass on a[3] shifted by 3.
import mult_share_pkg::*;

module mult_share_ctrl #(
   parameter bit RR_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [OPA_W-1:0]  req0_a,
   input  logic [OPB_W-1:0]  req0_b,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [OPA_W-1:0]  req1_a,
   input  logic [OPB_W-1:0]  req1_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [PROD_W-1:0] rsp_p,
   output logic              busy
);

   state_t             r_state;
   state_t             w_nextState;
   logic [OPA_W-1:0]   r_a;
   logic [OPB_W-1:0]   r_b;
   logic               r_id;
   logic [PROD_W-1:0]  r_acc;
   logic               w_grant0;
   logic               w_grant1;
   logic [2:0]         w_mulA;
   logic [3:0]         w_mulB;
   logic [6:0]         w_mulP;

   rr_arb2 #(
      .RR_EN (RR_EN)
   ) u_arb (
      .clk      (clk),
      .rst      (rst),
      .i_enable (r_state == IDLE),
      .i_valid0 (req0_valid),
      .i_valid1 (req1_valid),
      .o_grant0 (w_grant0),
      .o_grant1 (w_grant1)
   );

   multiplier_sam u_mul (
      .A_in (w_mulA),
      .B_in (w_mulB),
      .P    (w_mulP)
   );

   // Advance the FSM and steer the multiplier; it idles at zero outside LO/HI.
   always_comb begin
      w_nextState = r_state;
      w_mulA      = 3'd0;
      w_mulB      = 4'd0;
      case (r_state)
         IDLE: begin
            if (w_grant0 || w_grant1) begin
               w_nextState = LO;
            end
         end
         LO: begin
            w_mulA      = r_a[2:0];
            w_mulB      = r_b;
            w_nextState = HI;
         end
         HI: begin
            w_mulA      = {2'b00, r_a[3]};
            w_mulB      = r_b;
            w_nextState = DONE;
         end
         DONE: begin
            if (rsp_ready) begin
               w_nextState = IDLE;
            end
         end
      endcase
   end

   // State register; reset abandons any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Latch operands on acceptance and build the product over two passes.
   // The accumulator doubles as the response register and holds through DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a   <= '0;
         r_b   <= '0;
         r_id  <= 1'b0;
         r_acc <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant0) begin
                  r_a  <= req0_a;
                  r_b  <= req0_b;
                  r_id <= 1'b0;
               end else if (w_grant1) begin
                  r_a  <= req1_a;
                  r_b  <= req1_b;
                  r_id <= 1'b1;
               end
            end
            LO:      r_acc <= {1'b0, w_mulP};
            HI:      r_acc <= r_acc + hiTerm(w_mulP);
            default: ;
         endcase
      end
   end

   assign req0_ready = w_grant0;
   assign req1_ready = w_grant1;
   assign rsp_valid  = (r_state == DONE);
   assign rsp_p      = r_acc;
   assign rsp_id     = r_id;
   assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl: a round-robin instance and a
// fixed-priority instance share all inputs and run in lockstep.
module tb_mult_share_ctrl;

   logic       clk;
   logic       rst;
   logic       req0_valid;
   logic [3:0] req0_a;
   logic [3:0] req0_b;
   logic       req1_valid;
   logic [3:0] req1_a;
   logic [3:0] req1_b;
   logic       rsp_ready;

   logic       req0_ready;
   logic       req1_ready;
   logic       rsp_valid;
   logic       rsp_id;
   logic [7:0] rsp_p;
   logic       busy;

   logic       fpReq0Ready;
   logic       fpReq1Ready;
   logic       fpRspValid;
   logic       fpRspId;
   logic [7:0] fpRspP;
   logic       fpBusy;

   int checks;
   int failures;

   mult_share_ctrl #(
      .RR_EN (1'b1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_p      (rsp_p),
      .busy       (busy)
   );

   mult_share_ctrl #(
      .RR_EN (1'b0)
   ) dutFp (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (fpReq0Ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (fpReq1Ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .rsp_valid  (fpRspValid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (fpRspId),
      .rsp_p      (fpRspP),
      .busy       (fpBusy)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One comparison point.
   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Present one request, confirm acceptance, and check its response.
   task automatic applyStimulus(input logic id, input logic [3:0] a, input logic [3:0] b, input logic [7:0] prod);
      if (id) begin
         req1_valid = 1'b1; req1_a = a; req1_b = b;
      end else begin
         req0_valid = 1'b1; req0_a = a; req0_b = b;
      end
      #1;
      checkOutput("op_ready0", 8'(req0_ready), 8'(!id));
      checkOutput("op_ready1", 8'(req1_ready), 8'(id));
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      checkOutput("op_lo_valid", 8'(rsp_valid), 8'd0);
      checkOutput("op_lo_busy", 8'(busy), 8'd1);
      tick();
      tick();
      checkOutput("op_rsp_valid", 8'(rsp_valid), 8'd1);
      checkOutput("op_rsp_p", rsp_p, prod);
      checkOutput("op_rsp_id", 8'(rsp_id), 8'(id));
      tick();
      checkOutput("op_after_valid", 8'(rsp_valid), 8'd0);
   endtask

   initial begin
      logic [7:0] rrProd [4];
      logic       rrId   [4];
      checks     = 0;
      failures   = 0;
      rst        = 1'b1;
      req0_valid = 1'b0; req0_a = 4'd0; req0_b = 4'd0;
      req1_valid = 1'b0; req1_a = 4'd0; req1_b = 4'd0;
      rsp_ready  = 1'b1;
      tick();
      tick();

      // Reset values
      checkOutput("rst_valid", 8'(rsp_valid), 8'd0);
      checkOutput("rst_busy", 8'(busy), 8'd0);
      checkOutput("rst_p", rsp_p, 8'd0);
      checkOutput("rst_id", 8'(rsp_id), 8'd0);
      rst = 1'b0;
      tick();
      checkOutput("idle_ready0", 8'(req0_ready), 8'd0);
      checkOutput("idle_ready1", 8'(req1_ready), 8'd0);

      // Single op on req0: 13 x 11
      $display("[TB] single op");
      applyStimulus(1'b0, 4'd13, 4'd11, 8'd143);

      // Operand corners on req1
      $display("[TB] operand corners");
      applyStimulus(1'b1, 4'd15, 4'd15, 8'd225);
      applyStimulus(1'b1, 4'd8,  4'd15, 8'd120);
      applyStimulus(1'b1, 4'd7,  4'd15, 8'd105);
      applyStimulus(1'b1, 4'd0,  4'd9,  8'd0);
      applyStimulus(1'b1, 4'd9,  4'd0,  8'd0);

      // Contention: round robin alternates, fixed priority always picks req0
      $display("[TB] contention");
      rrProd[0] = 8'd15; rrProd[1] = 8'd42; rrProd[2] = 8'd15; rrProd[3] = 8'd42;
      rrId[0]   = 1'b0;  rrId[1]   = 1'b1;  rrId[2]   = 1'b0;  rrId[3]   = 1'b1;
      req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd5;
      req1_valid = 1'b1; req1_a = 4'd6; req1_b = 4'd7;
      for (int i = 0; i < 4; i++) begin
         #1;
         checkOutput("rr_ready0", 8'(req0_ready), 8'(!rrId[i]));
         checkOutput("rr_ready1", 8'(req1_ready), 8'(rrId[i]));
         checkOutput("fp_ready0", 8'(fpReq0Ready), 8'd1);
         checkOutput("fp_ready1", 8'(fpReq1Ready), 8'd0);
         tick();
         checkOutput("fp_lo_ready1", 8'(fpReq1Ready), 8'd0);
         tick();
         tick();
         checkOutput("rr_p", rsp_p, rrProd[i]);
         checkOutput("rr_id", 8'(rsp_id), 8'(rrId[i]));
         checkOutput("fp_p", fpRspP, 8'd15);
         checkOutput("fp_id", 8'(fpRspId), 8'd0);
         tick();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;

      // Backpressure: response held for 10 cycles while req1 waits
      $display("[TB] backpressure");
      rsp_ready  = 1'b0;
      req0_valid = 1'b1; req0_a = 4'd5; req0_b = 4'd6;
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_a = 4'd4; req1_b = 4'd9;
      tick();
      tick();
      for (int i = 0; i < 10; i++) begin
         checkOutput("bp_valid", 8'(rsp_valid), 8'd1);
         checkOutput("bp_p", rsp_p, 8'd30);
         checkOutput("bp_id", 8'(rsp_id), 8'd0);
         checkOutput("bp_ready1", 8'(req1_ready), 8'd0);
         tick();
      end
      rsp_ready = 1'b1;
      #1;
      checkOutput("bp_hs_ready1", 8'(req1_ready), 8'd0);
      tick();
      checkOutput("bp_after_valid", 8'(rsp_valid), 8'd0);
      checkOutput("bp_accept1", 8'(req1_ready), 8'd1);
      tick();
      req1_valid = 1'b0;
      tick();
      tick();
      checkOutput("bp2_valid", 8'(rsp_valid), 8'd1);
      checkOutput("bp2_p", rsp_p, 8'd36);
      checkOutput("bp2_id", 8'(rsp_id), 8'd1);
      tick();

      // Reset during the high pass of 12 x 12
      $display("[TB] reset mid-operation");
      req0_valid = 1'b1; req0_a = 4'd12; req0_b = 4'd12;
      tick();
      req0_valid = 1'b0;
      tick();
      checkOutput("hi_busy", 8'(busy), 8'd1);
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_valid", 8'(rsp_valid), 8'd0);
      checkOutput("mid_rst_busy", 8'(busy), 8'd0);
      checkOutput("mid_rst_p", rsp_p, 8'd0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("post_rst_valid", 8'(rsp_valid), 8'd0);
      end
      applyStimulus(1'b0, 4'd2, 4'd3, 8'd6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
